// File: rtl/mem_port_arbiter.sv
// Arbitrates the unified memory port between instruction fetch (IF) and load/store (D) requesters.
// Define ROUND_ROBIN_EN for alternating priority on simultaneous requests; default is fixed D-first.
module mem_port_arbiter #(
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned MEM_LAT = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [DW-1:0] if_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_WAIT,
        ST_RESP
    } state_t;

    typedef enum logic {
        OWN_IF,
        OWN_D
    } owner_t;

    localparam logic [3:0] LAT4 = 4'(MEM_LAT);

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    owner_t        owner_q, owner_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          we_q, we_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] if_rdata_q, if_rdata_d;
    logic [DW-1:0] d_rdata_q, d_rdata_d;
`ifdef ROUND_ROBIN_EN
    owner_t        last_q, last_d;
`endif

    logic grant_if_c;
    logic grant_d_c;

    always_comb begin
        grant_if_c = 1'b0;
        grant_d_c  = 1'b0;
        if (state_q == ST_IDLE) begin
`ifdef ROUND_ROBIN_EN
            // On contention the requester not served last wins.
            if (if_req && d_req) begin
                if (last_q == OWN_IF) grant_d_c  = 1'b1;
                else                  grant_if_c = 1'b1;
            end else begin
                grant_d_c  = d_req;
                grant_if_c = if_req;
            end
`else
            grant_d_c  = d_req;
            grant_if_c = if_req & ~d_req;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        owner_d    = owner_q;
        addr_d     = addr_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
`ifdef ROUND_ROBIN_EN
        last_d     = last_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (grant_d_c) begin
                    owner_d = OWN_D;
                    addr_d  = d_addr;
                    we_d    = d_we;
                    wdata_d = d_wdata;
                    state_d = ST_ACCESS;
`ifdef ROUND_ROBIN_EN
                    last_d  = OWN_D;
`endif
                end else if (grant_if_c) begin
                    owner_d = OWN_IF;
                    addr_d  = if_addr;
                    we_d    = 1'b0;
                    wdata_d = '0;
                    state_d = ST_ACCESS;
`ifdef ROUND_ROBIN_EN
                    last_d  = OWN_IF;
`endif
                end
            end
            ST_ACCESS: begin
                cnt_d   = LAT4;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
                // Read data is valid in the final wait cycle; stores return zero.
                if (cnt_q <= 4'd1) begin
                    state_d = ST_RESP;
                    if (owner_q == OWN_D) d_rdata_d  = we_q ? '0 : mem_rdata;
                    else                  if_rdata_d = mem_rdata;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            owner_q    <= OWN_IF;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
`ifdef ROUND_ROBIN_EN
            last_q     <= OWN_IF;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            owner_q    <= owner_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
`ifdef ROUND_ROBIN_EN
            last_q     <= last_d;
`endif
        end
    end

    assign if_gnt    = grant_if_c;
    assign d_gnt     = grant_d_c;
    assign if_rvalid = (state_q == ST_RESP) && (owner_q == OWN_IF);
    assign d_rvalid  = (state_q == ST_RESP) && (owner_q == OWN_D);
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign mem_en    = (state_q == ST_ACCESS);
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance at MEM_LAT=1, one at MEM_LAT=4,
// each with a memory model whose read data is valid only MEM_LAT cycles after mem_en.
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // MEM_LAT=1 instance
    logic        if_req, if_gnt, if_rvalid, d_req, d_we, d_gnt, d_rvalid;
    logic        mem_en, mem_we, busy;
    logic [31:0] if_addr, if_rdata, d_addr, d_wdata, d_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [31:0] mem1_data = 32'h0;
    logic [3:0]  cd1 = 4'd0;

    // MEM_LAT=4 instance
    logic        b_if_req, b_if_gnt, b_if_rvalid, b_d_req, b_d_we, b_d_gnt, b_d_rvalid;
    logic        b_mem_en, b_mem_we, b_busy;
    logic [31:0] b_if_addr, b_if_rdata, b_d_addr, b_d_wdata, b_d_rdata;
    logic [31:0] b_mem_addr, b_mem_wdata, b_mem_rdata;
    logic [31:0] mem4_data = 32'h0;
    logic [3:0]  cd4 = 4'd0;

    mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(1)) u_dut1 (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
        .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt),
        .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(4)) u_dut4 (
        .clk(clk), .reset(reset),
        .if_req(b_if_req), .if_addr(b_if_addr), .if_gnt(b_if_gnt), .if_rvalid(b_if_rvalid),
        .if_rdata(b_if_rdata),
        .d_req(b_d_req), .d_we(b_d_we), .d_addr(b_d_addr), .d_wdata(b_d_wdata), .d_gnt(b_d_gnt),
        .d_rvalid(b_d_rvalid), .d_rdata(b_d_rdata),
        .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
        .mem_rdata(b_mem_rdata), .busy(b_busy)
    );

    always @(posedge clk) begin
        if (mem_en) cd1 <= 4'd1;
        else if (cd1 != 4'd0) cd1 <= cd1 - 4'd1;
        if (b_mem_en) cd4 <= 4'd4;
        else if (cd4 != 4'd0) cd4 <= cd4 - 4'd1;
    end
    assign mem_rdata   = (cd1 == 4'd1) ? mem1_data : 32'hBAD0_BAD0;
    assign b_mem_rdata = (cd4 == 4'd1) ? mem4_data : 32'hBAD0_BAD0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    // One transaction on the MEM_LAT=4 instance; measures gnt->rvalid latency and busy span.
    task automatic b_txn(input logic is_d, input logic [31:0] addr, input logic [31:0] data,
                         input string tag);
        int lat;
        int bcnt;
        logic [31:0] rd;
        logic other;
        @(posedge clk); #1;
        mem4_data = data;
        if (is_d) begin b_d_req = 1'b1; b_d_we = 1'b0; b_d_addr = addr; end
        else begin b_if_req = 1'b1; b_if_addr = addr; end
        #2;
        check({tag, "_gnt"}, is_d ? b_d_gnt : b_if_gnt, 32'd1);
        lat = 0; bcnt = 0; rd = '0; other = 1'b0;
        for (int k = 1; k <= 20 && lat == 0; k++) begin
            @(posedge clk); #1;
            b_d_req = 1'b0; b_if_req = 1'b0;
            #2;
            if (k == 1) begin
                check({tag, "_mem_en"}, b_mem_en, 32'd1);
                check({tag, "_mem_addr"}, b_mem_addr, addr);
                check({tag, "_mem_we"}, b_mem_we, 32'd0);
                if (is_d) check({tag, "_mem_wdata"}, b_mem_wdata, 32'h5A5A5A5A);
            end
            if (is_d ? b_if_rvalid : b_d_rvalid) other = 1'b1;
            if (is_d ? b_d_rvalid : b_if_rvalid) begin
                lat = k;
                rd  = is_d ? b_d_rdata : b_if_rdata;
            end else if (b_busy) begin
                bcnt++;
            end
        end
        check({tag, "_latency"}, lat, 32'd6);
        check({tag, "_busy_cycles"}, bcnt, 32'd5);
        check({tag, "_rdata"}, rd, data);
        check({tag, "_other_rvalid"}, other, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int ng;
        int both;
        int gcyc[4];
        logic who[4];
        logic exp_who;
        int rv;

        if_req = 0; if_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
        b_if_req = 0; b_if_addr = '0; b_d_req = 0; b_d_we = 0; b_d_addr = '0;
        b_d_wdata = 32'h5A5A5A5A;
        reset = 1'b0;

        repeat (2) @(posedge clk);
        #3;
        check("rst_busy", busy, 32'd0);
        check("rst_mem_en", mem_en, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_we", mem_we, 32'd0);
        check("rst_if_rvalid", if_rvalid, 32'd0);
        check("rst_d_rvalid", d_rvalid, 32'd0);
        check("rst_if_rdata", if_rdata, 32'd0);
        check("rst_d_rdata", d_rdata, 32'd0);
        check("rst_b_busy", b_busy, 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;

        // Fetch, MEM_LAT=1
        @(posedge clk); #1;
        if_req = 1'b1; if_addr = 32'h100; mem1_data = 32'h00500093;
        #2;
        check("t1_if_gnt", if_gnt, 32'd1);
        check("t1_d_gnt", d_gnt, 32'd0);
        @(posedge clk); #1;
        if_req = 1'b0;
        #2;
        check("t1_mem_en", mem_en, 32'd1);
        check("t1_mem_addr", mem_addr, 32'h100);
        check("t1_mem_we", mem_we, 32'd0);
        @(posedge clk); #3;
        check("t1_rvalid_early", if_rvalid, 32'd0);
        check("t1_busy_wait", busy, 32'd1);
        @(posedge clk); #3;
        check("t1_if_rvalid", if_rvalid, 32'd1);
        check("t1_if_rdata", if_rdata, 32'h00500093);
        check("t1_d_rvalid", d_rvalid, 32'd0);
        @(posedge clk); #3;
        check("t1_rvalid_pulse", if_rvalid, 32'd0);
        check("t1_busy_idle", busy, 32'd0);
        check("t1_rdata_hold", if_rdata, 32'h00500093);

        // Store, MEM_LAT=1
        @(posedge clk); #1;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2000; d_wdata = 32'hDEADBEEF;
        mem1_data = 32'h12345678;
        #2;
        check("t2_d_gnt", d_gnt, 32'd1);
        check("t2_if_gnt", if_gnt, 32'd0);
        @(posedge clk); #1;
        d_req = 1'b0;
        #2;
        check("t2_mem_en", mem_en, 32'd1);
        check("t2_mem_we", mem_we, 32'd1);
        check("t2_mem_addr", mem_addr, 32'h2000);
        check("t2_mem_wdata", mem_wdata, 32'hDEADBEEF);
        @(posedge clk); #3;
        check("t2_if_rvalid_wait", if_rvalid, 32'd0);
        @(posedge clk); #3;
        check("t2_d_rvalid", d_rvalid, 32'd1);
        check("t2_d_rdata", d_rdata, 32'd0);
        check("t2_if_rvalid", if_rvalid, 32'd0);
        check("t2_if_rdata_hold", if_rdata, 32'h00500093);
        @(posedge clk); #3;
        check("t2_mem_en_off", mem_en, 32'd0);
        check("t2_mem_we_hold", mem_we, 32'd1);
        check("t2_mem_wdata_hold", mem_wdata, 32'hDEADBEEF);
        d_we = 1'b0;

        // Fetch request raised during WAIT is deferred to the first IDLE cycle
        @(posedge clk); #1;
        d_req = 1'b1; d_addr = 32'h10; mem1_data = 32'hABCD0001;
        #2;
        check("t6_d_gnt", d_gnt, 32'd1);
        @(posedge clk); #1;
        d_req = 1'b0;
        @(posedge clk); #1;
        if_req = 1'b1; if_addr = 32'h200;
        #2;
        check("t6_no_gnt_wait", if_gnt, 32'd0);
        @(posedge clk); #3;
        check("t6_no_gnt_resp", if_gnt, 32'd0);
        check("t6_d_rvalid", d_rvalid, 32'd1);
        check("t6_d_rdata", d_rdata, 32'hABCD0001);
        @(posedge clk); #3;
        check("t6_gnt_idle", if_gnt, 32'd1);
        @(posedge clk); #1;
        if_req = 1'b0;
        repeat (4) @(posedge clk);

        // Continuous contention after a fresh reset
        #1; reset = 1'b0;
        @(posedge clk); #1; reset = 1'b1;
        @(posedge clk); #1;
        if_req = 1'b1; if_addr = 32'h300; d_req = 1'b1; d_addr = 32'h400;
        ng = 0; both = 0;
        for (int i = 0; i < 4; i++) begin gcyc[i] = 0; who[i] = 1'b0; end
        for (int c = 0; c < 40 && ng < 4; c++) begin
            #2;
            if (if_gnt && d_gnt) both++;
            if (if_gnt || d_gnt) begin
                who[ng]  = d_gnt;
                gcyc[ng] = c;
                ng++;
            end
            @(posedge clk); #1;
        end
        if_req = 1'b0; d_req = 1'b0;
        check("t3_grant_count", ng, 32'd4);
        check("t3_gnt_exclusive", both, 32'd0);
        for (int i = 0; i < 4; i++) begin
`ifdef ROUND_ROBIN_EN
            exp_who = (i % 2 == 0);
`else
            exp_who = 1'b1;
`endif
            check($sformatf("t3_grant%0d_is_d", i), who[i], exp_who);
        end
        check("t3_grant_spacing", gcyc[1] - gcyc[0], 32'd4);
        repeat (4) @(posedge clk);

        // MEM_LAT=4 load
        b_txn(1'b1, 32'h40, 32'hCAFEF00D, "t4");

        // Reset during WAIT abandons the transaction
        @(posedge clk); #1;
        b_d_req = 1'b1; b_d_we = 1'b0; b_d_addr = 32'h44; mem4_data = 32'h00000077;
        #2;
        check("t5_gnt", b_d_gnt, 32'd1);
        @(posedge clk); #1;
        b_d_req = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        reset = 1'b0;
        #2;
        check("t5_busy", b_busy, 32'd0);
        check("t5_mem_en", b_mem_en, 32'd0);
        check("t5_d_rvalid", b_d_rvalid, 32'd0);
        check("t5_d_rdata", b_d_rdata, 32'd0);
        rv = 0;
        repeat (2) begin
            @(posedge clk); #3;
            rv += int'(b_d_rvalid);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (8) begin
            @(posedge clk); #3;
            rv += int'(b_d_rvalid);
        end
        check("t5_no_rvalid", rv, 32'd0);
        b_txn(1'b0, 32'h80, 32'h11112222, "t5_after");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
